// File: rtl/flash_loader.sv
// Boot loader: receives a framed byte stream from a host, programs the words into flash,
// and holds the CPU in reset until a frame with a good checksum has been written.
module flash_loader #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [DATA_W-1:0] flash_in,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_wr,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int BYTES = DATA_W / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_LEN_LO = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_CSUM   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  logic [2:0]        state;
  logic [15:0]       len;
  logic [15:0]       idx;
  logic [7:0]        bcnt;
  logic [7:0]        sum;
  logic [DATA_W-1:0] word;
  logic [31:0]       idle_cnt;

  logic              accept;
  logic              timed;
  logic              timeout_hit;
  logic [DATA_W+7:0] word_cat;
  logic [DATA_W-1:0] word_next;

  always_comb begin
    byte_ready = (state == S_SYNC) || (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA) || (state == S_CSUM);
    flash_wr   = (state == S_WRITE);
    accept     = byte_valid && byte_ready;
    timed      = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA) ||
                 (state == S_CSUM);
    // Fires on the edge where the idle count would reach TIMEOUT.
    timeout_hit = timed && !accept && (idle_cnt == 32'(TIMEOUT - 1));
    word_cat    = {word, byte_in};
    word_next   = word_cat[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      sum        <= '0;
      word       <= '0;
      idle_cnt   <= '0;
      flash_in   <= '0;
      flash_addr <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (timed && !accept) idle_cnt <= idle_cnt + 32'd1;
      else                  idle_cnt <= '0;

      if (timeout_hit) begin
        state    <= S_ERR;
        err      <= 1'b1;
        cpu_hold <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (start) begin
              state    <= S_SYNC;
              cpu_hold <= 1'b1;
              done     <= 1'b0;
              err      <= 1'b0;
            end
          end
          S_SYNC: begin
            if (accept && byte_in == 8'hA5) begin
              state <= S_LEN_HI;
              sum   <= '0;
            end
          end
          S_LEN_HI: begin
            if (accept) begin
              len[15:8] <= byte_in;
              state     <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (accept) begin
              len[7:0] <= byte_in;
              idx      <= '0;
              bcnt     <= '0;
              sum      <= '0;
              state    <= ({len[15:8], byte_in} == 16'd0) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: begin
            if (accept) begin
              word <= word_next;
              sum  <= sum + byte_in;
              if (bcnt == 8'(BYTES - 1)) begin
                bcnt       <= '0;
                flash_in   <= word_next;
                flash_addr <= ADDR_W'(32'(BASE_ADDR) + 32'(idx));
                state      <= S_WRITE;
              end else begin
                bcnt <= bcnt + 8'd1;
              end
            end
          end
          S_WRITE: begin
            idx   <= idx + 16'd1;
            state <= ((17'(idx) + 17'd1) == 17'(len)) ? S_CSUM : S_DATA;
          end
          S_CSUM: begin
            if (accept) begin
              if (sum + byte_in == 8'd0) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
                state    <= S_IDLE;
              end else begin
                err   <= 1'b1;
                state <= S_ERR;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: table of frames with a write scoreboard, plus
// timeout and mid-frame reset sequences.
module tb_flash_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [15:0] flash_in;
  logic [15:0] flash_addr;
  logic        flash_wr;
  logic        cpu_hold;
  logic        done;
  logic        err;

  flash_loader #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .BASE_ADDR(32'h0100),
    .TIMEOUT  (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .flash_in  (flash_in),
    .flash_addr(flash_addr),
    .flash_wr  (flash_wr),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:15][7:0] bytes;
    int               len;
    int               nwr;
    logic [0:2][15:0] waddr;
    logic [0:2][15:0] wdata;
    logic             ok;
  } frame_t;

  frame_t      frames [5];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Each write strobe cycle must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (flash_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr got %h want none", {flash_addr, flash_in});
      end else begin
        mon_e = exp_q.pop_front();
        chk("flash_wr", {flash_addr, flash_in}, mon_e);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
    end
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sync_ready", byte_ready, 1);
    chk("sync_hold", cpu_hold, 1);
    chk("sync_clear", {done, err}, 0);
  endtask

  task automatic run_frame(input frame_t f);
    pulse_start();
    for (int i = 0; i < f.nwr; i++) exp_q.push_back({f.waddr[i], f.wdata[i]});
    for (int i = 0; i < f.len; i++) send_byte(f.bytes[i]);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("writes_left", exp_q.size(), 0);
    chk("done", done, f.ok);
    chk("err", err, !f.ok);
    chk("cpu_hold", cpu_hold, !f.ok);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k;

    frames[0] = '{bytes: {64'hA500021234ABCD42, 64'h0}, len: 8, nwr: 2,
                  waddr: {16'h0100, 16'h0101, 16'h0}, wdata: {16'h1234, 16'hABCD, 16'h0},
                  ok: 1'b1};
    frames[1] = '{bytes: {64'hA500021234ABCD43, 64'h0}, len: 8, nwr: 2,
                  waddr: {16'h0100, 16'h0101, 16'h0}, wdata: {16'h1234, 16'hABCD, 16'h0},
                  ok: 1'b0};
    frames[2] = '{bytes: {72'h00FF3CA500010007F9, 56'h0}, len: 9, nwr: 1,
                  waddr: {16'h0100, 16'h0, 16'h0}, wdata: {16'h0007, 16'h0, 16'h0},
                  ok: 1'b1};
    frames[3] = '{bytes: {32'hA5000000, 96'h0}, len: 4, nwr: 0,
                  waddr: {16'h0, 16'h0, 16'h0}, wdata: {16'h0, 16'h0, 16'h0}, ok: 1'b1};
    frames[4] = '{bytes: {80'hA50003FFFF0001800081, 48'h0}, len: 10, nwr: 3,
                  waddr: {16'h0100, 16'h0101, 16'h0102},
                  wdata: {16'hFFFF, 16'h0001, 16'h8000}, ok: 1'b1};

    #1 rst_n = 1'b0;
    #3;
    chk("rst_ready", byte_ready, 0);
    chk("rst_flash_in", flash_in, 0);
    chk("rst_flash_addr", flash_addr, 0);
    chk("rst_flash_wr", flash_wr, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", byte_ready, 0);

    for (int i = 0; i < 5; i++) run_frame(frames[i]);

    // Timeout after "A5 00" with a START in the middle that must be ignored.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    k = 0;
    #1 byte_valid = 1'b0;
    while (err !== 1'b1 && k < 200) begin
      @(posedge clk);
      k++;
      #1;
      if (k == 10) start = 1'b1;
      if (k == 11) start = 1'b0;
    end
    chk("timeout_cycles", k, 100);
    chk("timeout_hold", cpu_hold, 1);
    chk("timeout_done", done, 0);
    chk("timeout_ready", byte_ready, 0);

    // Asynchronous reset between the two bytes of a data word.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_flash", {flash_addr, flash_in}, 0);
    chk("mid_rst_wr", flash_wr, 0);
    chk("mid_rst_flags", {cpu_hold, done, err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_flags", {cpu_hold, done, err}, 0);
    run_frame(frames[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the flash word width in bits; it must be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, SHALL set the flash address width in bits.
REQ-003 Parameter BASE_ADDR, default 0, SHALL set the flash address of the first loaded word.
REQ-004 Parameter TIMEOUT, default 65535, SHALL set the maximum number of idle cycles allowed between accepted bytes inside a frame.
REQ-005 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 RST  in  1  SHALL be the reset: asynchronous, active-low.
REQ-007 START  in  1  SHALL be a one-cycle pulse that opens a load session.
REQ-008 BYTE_IN  in  8  SHALL carry the host byte stream.
REQ-009 BYTE_VALID  in  1  SHALL qualify BYTE_IN.
REQ-010 BYTE_READY  out  1  SHALL indicate the loader can accept a byte; a byte is consumed on a cycle with BYTE_VALID=1 and BYTE_READY=1.
REQ-011 FLASH_IN  out  DATA_W  SHALL be the word to program into FLASH.
REQ-012 FLASH_ADDR  out  ADDR_W  SHALL be the FLASH programming address.
REQ-013 FLASH_WR  out  1  SHALL be the FLASH write strobe.
REQ-014 CPU_HOLD  out  1  SHALL be high while the processor must be held in reset.
REQ-015 DONE  out  1  SHALL be high after a successful load.
REQ-016 ERR  out  1  SHALL be high after a failed load.

Function
REQ-017 The frame format SHALL be: sync byte 0xA5; word count N as 2 bytes, MSB first; N words of DATA_W/8 bytes each, MSB first; one checksum byte.
REQ-018 States SHALL be IDLE, SYNC, LEN_HI, LEN_LO, DATA, WRITE, CSUM and ERR_S.
REQ-019 IDLE: BYTE_READY=0; START -> SYNC, which sets CPU_HOLD=1 and clears DONE and ERR.
REQ-020 SYNC: BYTE_READY=1; byte 0xA5 -> LEN_HI; any other byte is discarded and the state stays SYNC; no timeout applies.
REQ-021 LEN_HI, then LEN_LO: capture N; after LEN_LO, N=0 -> CSUM, otherwise -> DATA with word index=0 and running sum=0.
REQ-022 DATA: BYTE_READY=1; shift each byte into the word register and add it to the 8-bit running sum (mod 256); after DATA_W/8 bytes -> WRITE.
REQ-023 WRITE: BYTE_READY=0; FLASH_WR=1 for exactly one cycle with FLASH_ADDR=(BASE_ADDR+index) mod 2^ADDR_W and FLASH_IN=the assembled word; then index increments and the next state is DATA, or CSUM if N words have been written.
REQ-024 Latency from acceptance of the last byte of a word to FLASH_WR SHALL be 1 cycle.
REQ-025 CSUM: BYTE_READY=1; if (running sum + checksum byte) mod 256 = 0, set DONE=1 and CPU_HOLD=0 and go to IDLE; otherwise go to ERR_S.
REQ-026 ERR_S: ERR=1, CPU_HOLD=1, BYTE_READY=0; START -> SYNC; no other exit except reset.
REQ-027 In LEN_HI, LEN_LO, DATA and CSUM, an idle counter SHALL clear on every accepted byte; reaching TIMEOUT -> ERR_S.
REQ-028 START SHALL be ignored in SYNC, LEN_HI, LEN_LO, DATA, WRITE and CSUM.
REQ-029 Outside WRITE, FLASH_WR SHALL be 0, and FLASH_ADDR and FLASH_IN SHALL hold their last values.
REQ-030 DONE and ERR SHALL be sticky until the next START or reset, and SHALL never both be 1.
REQ-031 N=65535 SHALL be supported; the address wraps modulo 2^ADDR_W.

Reset
REQ-032 While RST=0, the block SHALL enter IDLE immediately, regardless of state or of clock activity.
REQ-033 While RST=0, all outputs (BYTE_READY, FLASH_IN, FLASH_ADDR, FLASH_WR, CPU_HOLD, DONE, ERR) SHALL be 0, and all counters and sums SHALL be cleared.
REQ-034 A reset mid-frame SHALL abort the session with no further FLASH_WR.

Verification (DATA_W=16, BASE_ADDR=0x0100)
REQ-035 START, then A5 00 02 12 34 AB CD 42 -> FLASH_WR pulses at 0x0100/0x1234 and 0x0101/0xABCD; DONE=1, CPU_HOLD=0, ERR=0.
REQ-036 Same frame with checksum 0x43 -> both writes occur; ERR=1, DONE=0, CPU_HOLD stays 1; a new START returns to SYNC.
REQ-037 START, then 00 FF 3C A5 00 01 00 07 F9 -> leading bytes discarded; one write 0x0100/0x0007; DONE=1.
REQ-038 START, then A5 00 00 00 -> no FLASH_WR; DONE=1.
REQ-039 TIMEOUT=100; START, then A5 00 and silence -> ERR=1 exactly 100 cycles after the last accepted byte; START during the frame is ignored.
REQ-040 RST=0 asserted between the two data bytes of a word -> all outputs 0 asynchronously; a following START and a valid frame load correctly.
